// File: rtl/mux_arbiter_4_if.sv
// mux_arbiter_4_if: request/grant bus between four requesters, the arbiter and a 74153-style selector
interface mux_arbiter_4_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       en_n;
    logic       busy;
    modport master (input req, output gnt, sel, en_n, busy);
    modport slave (output req, input gnt, sel, en_n, busy);
endinterface

// File: rtl/mux_arbiter_4.sv
// mux_arbiter_4: round-robin owner of a shared 4:1 selector with glitch-safe sel/strobe sequencing
module mux_arbiter_4 #(
    parameter int HOLD_MAX = 8,
    parameter int HOLD_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    mux_arbiter_4_if.master   bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] GRANT = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;
    localparam logic [HOLD_W-1:0] CNT_TOP = HOLD_W'(HOLD_MAX == 0 ? 0 : HOLD_MAX - 1);

    logic [1:0]        state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [3:0]        gnt_q, gnt_d;
    logic              en_n_q, en_n_d;
    logic              busy_q, busy_d;
    logic [1:0]        win;
    logic              held, preempt;

    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        pick = p;
        for (int i = 3; i >= 0; i--)
            if (r[p + 2'(i)]) pick = p + 2'(i);
    endfunction

    always_comb begin
        win     = pick(bus.req, ptr_q);
        held    = bus.req[owner_q];
        preempt = HOLD_MAX != 0 && cnt_q == CNT_TOP && |(bus.req & ~(4'b1 << owner_q));
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, GAP: begin
                state_d = |bus.req ? SETUP : IDLE;
                owner_d = |bus.req ? win : owner_q;
            end
            SETUP: begin
                state_d = held ? GRANT : IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = (!held || preempt) ? GAP : GRANT;
                ptr_d   = (!held || preempt) ? owner_q + 2'd1 : ptr_q;
                cnt_d   = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + 1'b1;
            end
        endcase
        // outputs are decoded from the next state so they leave the flops clean
        gnt_d  = state_d == GRANT ? 4'b1 << owner_d : 4'b0;
        en_n_d = state_d != GRANT;
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            en_n_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            en_n_q  <= en_n_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.sel  = owner_q;
    assign bus.en_n = en_n_q;
    assign bus.busy = busy_q;
endmodule
